apb4_master: RTL and testbench

APB4 initiator (master) that converts a simple valid/ready request/response channel into single APB4 transfers. It lets a local controller (DMA, boot loader, test sequencer) drive APB4 slaves in the peripheral subsystem, such as the RNG, timers and UART, over the standard `apb4_if` slave port of those blocks. It supports one outstanding transfer at a time, waits for slave wait states, captures `pslverr`, and aborts stalled transfers with a programmable timeout.

---
 rtl/apb4_master_pkg.sv | 20 ++
 rtl/apb4_master_if.sv | 54 +++++
 rtl/apb4_mst_timeout.sv | 28 ++
 rtl/dffer.sv | 18 +
 rtl/apb4_master.sv | 149 ++++++++++++++
 tb/tb_apb4_master.sv | 302 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/apb4_master_pkg.sv
// Shared types and defaults for the APB4 initiator.
// Holds the FSM state encoding and the default bus/timeout sizing.
package apb4_master_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb4_mst_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb4_master_if.sv
// Request/response channel plus APB4 bus seen by the initiator.
// Signal names follow the initiator's port list; the master modport is the initiator's view.
interface apb4_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Both channels use valid/ready: a beat transfers on the rising clock edge
  // where valid and ready are both high; valid may not wait on ready.
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;
  logic [2:0]            req_prot_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );

endinterface

// File: rtl/apb4_mst_timeout.sv
// Clearable saturating ACCESS-cycle counter; expired marks the last allowed cycle.
// LIMIT = 0 keeps expired low forever.
module apb4_mst_timeout #(
  parameter int LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                     count <= '0;
    else if (clear)                   count <= '0;
    else if (enable && count != LAST) count <= count + 1'b1;
  end

  // The count equals the index of the current ACCESS cycle, so the flag is
  // high during the LIMIT-th cycle of a stalled transfer.
  assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/dffer.sv
// Enable register with asynchronous active-low reset to a parameterised value.
module dffer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q <= RST_VAL;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/apb4_master.sv
// APB4 initiator: turns one valid/ready request into a single APB4 transfer
// and returns a response carrying read data, slave error and timeout status.
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  apb4_master_if.master   bus,
  output apb4_mst_state_e dbg_state
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  apb4_mst_state_e state;
  logic            req_ready;
  logic            psel;
  logic            penable;
  logic            rsp_valid;

  logic            req_fire;
  logic            in_access;
  logic            access_done;
  logic            expired;

  assign req_fire    = req_ready && bus.req_valid_i;
  assign in_access   = (state == ST_ACCESS);
  assign access_done = in_access && (bus.pready_i || expired);

  apb4_mst_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear   (state == ST_SETUP),
    .enable  (in_access && !bus.pready_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            state     <= ST_SETUP;
            req_ready <= 1'b0;
            psel      <= 1'b1;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (access_done) begin
            state     <= ST_RESP;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // APB request fields load once at acceptance and then hold; reads carry
  // zero data and strobes on the bus.
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_WIDTH-1:0] strb_d;

  assign wdata_d = bus.req_write_i ? bus.req_wdata_i : '0;
  assign strb_d  = bus.req_write_i ? bus.req_strb_i  : '0;

  dffer #(.WIDTH(ADDR_WIDTH)) u_paddr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_fire), .d(bus.req_addr_i), .q(paddr)
  );
  dffer #(.WIDTH(1)) u_pwrite (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_fire), .d(bus.req_write_i), .q(pwrite)
  );
  dffer #(.WIDTH(DATA_WIDTH)) u_pwdata (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_fire), .d(wdata_d), .q(pwdata)
  );
  dffer #(.WIDTH(STRB_WIDTH)) u_pstrb (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_fire), .d(strb_d), .q(pstrb)
  );
  dffer #(.WIDTH(3)) u_pprot (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_fire), .d(bus.req_prot_i), .q(pprot)
  );

  // Response fields load on the last ACCESS cycle; pready wins over expiry,
  // so a missing pready there can only mean a timeout.
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;
  logic                  timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  assign rdata_d   = (bus.pready_i && !pwrite) ? bus.prdata_i : '0;
  assign err_d     = bus.pready_i ? bus.pslverr_i : 1'b1;
  assign timeout_d = !bus.pready_i;

  dffer #(.WIDTH(DATA_WIDTH)) u_rsp_rdata (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(access_done), .d(rdata_d), .q(rsp_rdata)
  );
  dffer #(.WIDTH(1)) u_rsp_err (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(access_done), .d(err_d), .q(rsp_err)
  );
  dffer #(.WIDTH(1)) u_rsp_timeout (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en(access_done), .d(timeout_d), .q(rsp_timeout)
  );

  assign bus.req_ready_o   = req_ready;
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_rdata_o   = rsp_rdata;
  assign bus.rsp_err_o     = rsp_err;
  assign bus.rsp_timeout_o = rsp_timeout;
  assign bus.paddr_o       = paddr;
  assign bus.pprot_o       = pprot;
  assign bus.psel_o        = psel;
  assign bus.penable_o     = penable;
  assign bus.pwrite_o      = pwrite;
  assign bus.pwdata_o      = pwdata;
  assign bus.pstrb_o       = pstrb;
  assign dbg_state         = state;

endmodule

// File: tb/tb_apb4_master.sv
// Bench for apb4_master: transaction-timeline model with a per-cycle compare,
// a responding APB slave, and directed transfers with literal expectations.
module tb_apb4_master;
  import apb4_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apb4_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  apb4_mst_state_e dbg_state;

  apb4_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- slave behaviour per transfer ----------------
  typedef struct {
    int          waits;
    logic [31:0] rdata;
    bit          slverr;
  } cfg_t;

  cfg_t cfg_q[$];
  cfg_t cur;

  // ---------------- transaction-timeline model ----------------
  // Handshake at cycle s: SETUP at s+1, ACCESS s+2..s+1+len, RESP from s+2+len.
  bit              active = 1'b0;
  int              cyc = 0;
  int              start_cyc = 0;
  int              len = 0;
  bit              m_to;
  logic [AW-1:0]   m_addr  = '0;
  logic            m_write = 1'b0;
  logic [DW-1:0]   m_wdata = '0;
  logic [SW-1:0]   m_strb  = '0;
  logic [2:0]      m_prot  = '0;
  logic [DW+1:0]   exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  = 1'b0;
      cyc     = 0;
      m_addr  = '0;
      m_write = 1'b0;
      m_wdata = '0;
      m_strb  = '0;
      m_prot  = '0;
      exp_q.delete();
    end else begin
      if (active && (cyc - start_cyc) >= 2 + len && bus.rsp_ready_i) begin
        active = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!active && bus.req_valid_i) begin
        if (cfg_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cfg_queue: handshake without a stimulus record");
        end else begin
          cur       = cfg_q.pop_front();
          active    = 1'b1;
          start_cyc = cyc;
          m_to      = (TO > 0) && (cur.waits >= TO);
          len       = m_to ? TO : cur.waits + 1;
          m_addr    = bus.req_addr_i;
          m_write   = bus.req_write_i;
          m_wdata   = bus.req_write_i ? bus.req_wdata_i : '0;
          m_strb    = bus.req_write_i ? bus.req_strb_i  : '0;
          m_prot    = bus.req_prot_i;
          exp_q.push_back({m_to, (m_to ? 1'b1 : cur.slverr),
                           ((m_to || bus.req_write_i) ? 32'h0 : cur.rdata)});
        end
      end
      cyc++;
    end
  end

  // ---------------- APB slave: pready after cur.waits ACCESS cycles ----------------
  int acc = 0;
  always @(negedge clk) begin
    if (bus.psel_o && bus.penable_o) begin
      bus.pready_i  = (acc == cur.waits);
      bus.prdata_i  = (acc == cur.waits) ? cur.rdata : $urandom;
      bus.pslverr_i = (acc == cur.waits) ? cur.slverr : 1'($urandom);
      acc++;
    end else begin
      acc           = 0;
      bus.pready_i  = 1'($urandom);
      bus.prdata_i  = $urandom;
      bus.pslverr_i = 1'($urandom);
    end
  end

  // ---------------- compare process ----------------
  int off;
  always @(negedge clk) begin
    if (rst_n) begin
      off = cyc - start_cyc;
      check("psel",      bus.psel_o,      active && off >= 1 && off <= 1 + len);
      check("penable",   bus.penable_o,   active && off >= 2 && off <= 1 + len);
      check("rsp_valid", bus.rsp_valid_o, active && off >= 2 + len);
      check("req_ready", bus.req_ready_o, !active);
      check("paddr",     bus.paddr_o,     m_addr);
      check("pwrite",    bus.pwrite_o,    m_write);
      check("pwdata",    bus.pwdata_o,    m_wdata);
      check("pstrb",     bus.pstrb_o,     m_strb);
      check("pprot",     bus.pprot_o,     m_prot);
      if (active && off >= 2 + len && exp_q.size() > 0) begin
        check("rsp_rdata",   bus.rsp_rdata_o,   exp_q[0][DW-1:0]);
        check("rsp_err",     bus.rsp_err_o,     exp_q[0][DW]);
        check("rsp_timeout", bus.rsp_timeout_o, exp_q[0][DW+1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    int n = 0;
    while (!bus.req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) bound_fail("accept_wait");
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_strb_i  = 4'($urandom);
    bus.req_write_i = 1'($urandom);
  endtask

  task automatic drive_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic [31:0] rdata, input bit slverr);
    cfg_t c;
    c.waits  = waits;
    c.rdata  = rdata;
    c.slverr = slverr;
    cfg_q.push_back(c);
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    bus.req_prot_i  = prot;
    bus.req_valid_i = 1'b1;
  endtask

  // Latency counts from the handshake edge: the negedge right after it is 1.
  task automatic wait_rsp(output int lat, output logic [DW+1:0] rsp);
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid_o) bound_fail("rsp_wait");
    rsp = {bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o};
  endtask

  task automatic finish_rsp(input int bp);
    repeat (bp) @(negedge clk);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input int waits, input logic [31:0] rdata, input bit slverr,
                      input int exp_lat, input logic [DW+1:0] exp_rsp);
    int            lat;
    logic [DW+1:0] rsp;
    drive_req(wr, addr, wdata, strb, prot, waits, rdata, slverr);
    wait_accept();
    wait_rsp(lat, rsp);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp"}, rsp, exp_rsp);
    check({tag, "_psel_in_resp"}, bus.psel_o, 0);
    finish_rsp(0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int            lat;
  logic [DW+1:0] rsp;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.req_prot_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pslverr_i   = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_state",     dbg_state,          ST_IDLE);
    check("rst_req_ready", bus.req_ready_o,    1);
    check("rst_psel",      bus.psel_o,         0);
    check("rst_penable",   bus.penable_o,      0);
    check("rst_rsp_valid", bus.rsp_valid_o,    0);
    check("rst_rsp",       {bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o}, 0);
    check("rst_apb",       {bus.paddr_o, bus.pwrite_o, bus.pstrb_o, bus.pprot_o}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // {timeout, err, rdata}
    xfer("zero_wait_write", 1'b1, 32'h0, 32'h1, 4'hF, 3'b000, 0, 32'h0, 1'b0,
         3, {2'b00, 32'h0});
    xfer("wait_read", 1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, 3'b010, 3, 32'hDEAD_BEEF, 1'b0,
         6, {2'b00, 32'hDEAD_BEEF});
    xfer("slverr_read", 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, 0, 32'h1234_5678, 1'b1,
         3, {2'b01, 32'h1234_5678});
    xfer("timeout_read", 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 1000, 32'h5555_AAAA, 1'b0,
         10, {2'b11, 32'h0});
    xfer("boundary_read", 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, 7, 32'hA5A5_0007, 1'b0,
         10, {2'b00, 32'hA5A5_0007});
    xfer("timeout_write", 1'b1, 32'h48, 32'hCAFE_0001, 4'h3, 3'b100, 1000, 32'h0, 1'b0,
         10, {2'b11, 32'h0});
    xfer("wait_write_err", 1'b1, 32'h1C, 32'h0BAD_F00D, 4'b0110, 3'b101, 2, 32'h7777_7777, 1'b1,
         5, {2'b01, 32'h0});

    // Response backpressure with a new request waiting during RESP.
    drive_req(1'b0, 32'hC, 32'h0, 4'h0, 3'b011, 1, 32'hCAFE_F00D, 1'b0);
    wait_accept();
    wait_rsp(lat, rsp);
    check("bp_latency", lat, 4);
    drive_req(1'b1, 32'h10, 32'h55, 4'h1, 3'b000, 0, 32'h0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready", bus.req_ready_o, 0);
      check("bp_rsp_hold", {bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_err_o, bus.rsp_rdata_o},
            {3'b100, 32'hCAFE_F00D});
    end
    finish_rsp(0);
    check("bp_next_not_taken", bus.psel_o, 0);
    wait_accept();
    wait_rsp(lat, rsp);
    check("bp_next_latency", lat, 3);
    check("bp_next_rsp", rsp, {2'b00, 32'h0});
    finish_rsp(0);

    // Asynchronous reset in the middle of a stalled ACCESS phase.
    drive_req(1'b1, 32'h20, 32'h1357_9BDF, 4'hF, 3'b111, 6, 32'h0, 1'b0);
    wait_accept();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_psel",      bus.psel_o,      0);
    check("mid_rst_penable",   bus.penable_o,   0);
    check("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
    check("mid_rst_req_ready", bus.req_ready_o, 1);
    check("mid_rst_apb", {bus.paddr_o, bus.pwrite_o, bus.pwdata_o, bus.pstrb_o, bus.pprot_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", {bus.rsp_valid_o, bus.req_ready_o, bus.psel_o}, 3'b010);
    end

    xfer("post_rst_write", 1'b1, 32'h24, 32'h0000_00FF, 4'h1, 3'b000, 0, 32'h0, 1'b0,
         3, {2'b00, 32'h0});

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
